// File: rtl/mem_fill_responder.sv
// mem_fill_responder
//   Memory-side responder for cache fill traffic. Word-addressed main memory
//   with a fixed read latency. It serves single-word reads, single-word writes
//   and 8-word block bursts (one 16-byte cache block, one word per cycle).
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active high
//   req_valid  request present
//   req_ready  responder can accept a request this cycle
//   req_wr     1 = write, 0 = read
//   req_burst  read only: 1 = 8-word block burst
//   req_addr   byte address (bit 0 ignored)
//   req_wdata  write data
//   rsp_valid  rsp_data valid this cycle (the only qualifying output)
//   rsp_data   read data, held while rsp_valid = 0
//   rsp_word   word index within the block
//   rsp_last   final word of the response
module mem_fill_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        rsp_word,
  output logic              rsp_last
);

  localparam int WADDR_W = ADDR_W - 1;
  localparam int BLK_W   = ADDR_W - 4;
  localparam int WORDS   = 2 ** WADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_r;
  logic [2:0]           cnt_r;
  logic [BLK_W-1:0]     base_r;
  logic                 ready_r;

  logic [DATA_W-1:0]    mem_r [WORDS];

  logic                 accept_s;
  logic                 issue_valid_s;
  logic [WADDR_W-1:0]   issue_addr_s;
  logic [2:0]           issue_word_s;
  logic                 issue_last_s;
  logic [DATA_W-1:0]    issue_data_s;
  logic                 unused_addr_lsb_s;

  logic                 pipe_valid_r [LATENCY];
  logic [DATA_W-1:0]    pipe_data_r  [LATENCY];
  logic [2:0]           pipe_word_r  [LATENCY];
  logic                 pipe_last_r  [LATENCY];

  // ready_r already reflects IDLE after the reset edge; masking with rst keeps
  // the port low during reset and high in the very first cycle after release.
  assign req_ready         = ready_r & ~rst;
  assign accept_s          = req_valid & req_ready;
  assign unused_addr_lsb_s = req_addr[0];

  // Read data is sampled from the array in the issue cycle, so a later write
  // cannot disturb a word that is already travelling down the pipeline.
  assign issue_data_s = mem_r[issue_addr_s];

  // Select which word (if any) is issued into the response pipeline this cycle.
  always_comb begin
    issue_valid_s = 1'b0;
    issue_addr_s  = {WADDR_W{1'b0}};
    issue_word_s  = 3'd0;
    issue_last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !req_wr) begin
          issue_valid_s = 1'b1;
          if (req_burst) begin
            // Burst word 0 comes straight from the request; the block base is
            // latched for words 1..7.
            issue_addr_s = {req_addr[ADDR_W-1:4], 3'd0};
            issue_word_s = 3'd0;
            issue_last_s = 1'b0;
          end else begin
            issue_addr_s = req_addr[ADDR_W-1:1];
            issue_word_s = req_addr[3:1];
            issue_last_s = 1'b1;
          end
        end else begin
          issue_valid_s = 1'b0;
        end
      end
      ST_BURST: begin
        // Word index wraps inside the block: no carry into the block base.
        issue_valid_s = 1'b1;
        issue_addr_s  = {base_r, cnt_r};
        issue_word_s  = cnt_r;
        issue_last_s  = (cnt_r == 3'd7);
      end
      default: begin
        issue_valid_s = 1'b0;
      end
    endcase
  end

  // Request FSM: IDLE accepts anything, BURST walks words 1..7 of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      base_r  <= {BLK_W{1'b0}};
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && !req_wr && req_burst) begin
            state_r <= ST_BURST;
            cnt_r   <= 3'd1;
            base_r  <= req_addr[ADDR_W-1:4];
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_BURST: begin
          if (cnt_r == 3'd7) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            ready_r <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 3'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 3'd0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Backing store write port; the array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept_s && req_wr) begin
      mem_r[req_addr[ADDR_W-1:1]] <= req_wdata;
    end
  end

  // Fixed-latency response pipeline; payload only moves with a valid entry so
  // the outputs hold the last delivered response while rsp_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid_r[i] <= 1'b0;
        pipe_data_r[i]  <= {DATA_W{1'b0}};
        pipe_word_r[i]  <= 3'd0;
        pipe_last_r[i]  <= 1'b0;
      end
    end else begin
      pipe_valid_r[0] <= issue_valid_s;
      if (issue_valid_s) begin
        pipe_data_r[0] <= issue_data_s;
        pipe_word_r[0] <= issue_word_s;
        pipe_last_r[0] <= issue_last_s;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        if (pipe_valid_r[i-1]) begin
          pipe_data_r[i] <= pipe_data_r[i-1];
          pipe_word_r[i] <= pipe_word_r[i-1];
          pipe_last_r[i] <= pipe_last_r[i-1];
        end
      end
    end
  end

  assign rsp_valid = pipe_valid_r[LATENCY-1];
  assign rsp_data  = pipe_data_r[LATENCY-1];
  assign rsp_word  = pipe_word_r[LATENCY-1];
  assign rsp_last  = pipe_last_r[LATENCY-1];

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder
//   Scoreboard bench for mem_fill_responder: a word-level memory model produces
//   the expected responses (with their due cycle) when a request is accepted,
//   and a monitor compares them against the DUT outputs.
module tb_mem_fill_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_burst;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_word;
  logic        rsp_last;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [2:0]  word;
    logic        last;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] mdl [int];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  mem_fill_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_word  (rsp_word),
    .rsp_last  (rsp_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mdl_rd(input int w);
    if (mdl.exists(w)) return mdl[w];
    return 16'h0000;
  endfunction

  // Compare each expected response in its due cycle; flag any response nobody expects.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_data",  32'(rsp_data),  32'(sb_q[0].data));
      check_eq("rsp_word",  32'(rsp_word),  32'(sb_q[0].word));
      check_eq("rsp_last",  32'(rsp_last),  32'(sb_q[0].last));
      sb_q.delete(0);
    end else if (rsp_valid === 1'b1) begin
      check_eq("unexpected_rsp", 32'(rsp_valid), 32'd0);
    end
  end

  // Drive one request from #1 after a rising edge, hold it until accepted,
  // update the model and push expected responses at the accept cycle.
  task automatic do_req(input logic wr, input logic burst, input logic [15:0] addr,
                        input logic [15:0] wdata, output int acc);
    int n;
    n   = 0;
    acc = -1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check_eq("accept_timeout", 32'(req_ready), 32'd1);
    end else begin
      acc = cyc;
      if (wr) begin
        mdl[int'(addr[15:1])] = wdata;
      end else if (burst) begin
        for (int k = 0; k < 8; k++) begin
          logic [2:0] kk;
          exp_t e;
          kk     = 3'(k);
          e.due  = acc + LAT + k;
          e.data = mdl_rd(int'({addr[15:4], kk}));
          e.word = kk;
          e.last = (k == 7);
          sb_q.push_back(e);
        end
      end else begin
        exp_t e;
        e.due  = acc + LAT;
        e.data = mdl_rd(int'(addr[15:1]));
        e.word = addr[3:1];
        e.last = 1'b1;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been seen.
  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0) break;
    end
    check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    int a0, a1, a2, t;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_burst = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;

    // T1: reset for two edges
    @(posedge clk);
    @(negedge clk);
    check_eq("t1_ready_in_rst", 32'(req_ready), 32'd0);
    check_eq("t1_valid_in_rst", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t1_ready_after", 32'(req_ready), 32'd1);
    check_eq("t1_rsp_data",    32'(rsp_data),  32'd0);
    check_eq("t1_rsp_word",    32'(rsp_word),  32'd0);
    check_eq("t1_rsp_last",    32'(rsp_last),  32'd0);
    @(posedge clk);
    #1;

    // T2: write then read in the very next cycle (odd byte address)
    do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, a0);
    do_req(1'b0, 1'b0, 16'h0011, 16'h0000, a1);
    check_eq("t2_b2b", 32'(a1), 32'(a0 + 1));
    drain();
    #1;

    // T3: three back-to-back single reads, then held outputs
    do_req(1'b1, 1'b0, 16'h0000, 16'h1111, a0);
    do_req(1'b1, 1'b0, 16'h0002, 16'h2222, a0);
    do_req(1'b1, 1'b0, 16'h0004, 16'h3333, a0);
    do_req(1'b0, 1'b0, 16'h0000, 16'h0000, a0);
    do_req(1'b0, 1'b0, 16'h0002, 16'h0000, a1);
    do_req(1'b0, 1'b0, 16'h0004, 16'h0000, a2);
    check_eq("t3_b2b", 32'(a2), 32'(a0 + 2));
    drain();
    @(negedge clk);
    check_eq("t3_hold_valid", 32'(rsp_valid), 32'd0);
    check_eq("t3_hold_data",  32'(rsp_data),  32'h3333);
    check_eq("t3_hold_word",  32'(rsp_word),  32'd2);
    @(posedge clk);
    #1;

    // T4: block burst starting mid-block, ready timeline
    for (int k = 0; k < 8; k++) begin
      do_req(1'b1, 1'b0, 16'(16'h0120 + 2 * k), 16'(16'hA000 + k), a0);
    end
    do_req(1'b0, 1'b1, 16'h0126, 16'h0000, t);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check_eq("t4_ready_busy", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check_eq("t4_ready_t8", 32'(req_ready), 32'd1);
    drain();
    #1;

    // T5: write held during a burst, then read it back
    do_req(1'b0, 1'b1, 16'h0120, 16'h0000, t);
    repeat (2) @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 16'h0124, 16'h5555, a0);
    check_eq("t5_wr_accept", 32'(a0), 32'(t + 8));
    do_req(1'b0, 1'b0, 16'h0124, 16'h0000, a1);
    check_eq("t5_rd_accept", 32'(a1), 32'(t + 9));
    drain();
    #1;

    // T7: burst on the top block wraps inside the block; single read right after it
    for (int k = 0; k < 8; k++) begin
      do_req(1'b1, 1'b0, 16'(16'hFFF0 + 2 * k), 16'(16'hC000 + k), a0);
    end
    do_req(1'b0, 1'b1, 16'hFFFA, 16'h0000, t);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, a0);
    check_eq("t7_rd_after_burst", 32'(a0), 32'(t + 8));
    drain();
    #1;

    // T6: reset in the middle of a burst drops everything in flight
    do_req(1'b0, 1'b1, 16'h0120, 16'h0000, t);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    sb_q.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t6_ready_after", 32'(req_ready), 32'd1);
    check_eq("t6_rsp_data",    32'(rsp_data),  32'd0);
    for (int k = 0; k < 6; k++) begin
      check_eq("t6_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 1'b0, 16'h0124, 16'h0000, a0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
